// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the load/store engine: RV32I memory funct3 codes,
// FSM state encoding and the access legality check.
package mem_access_unit_pkg;

    localparam logic [2:0] MEM_F3_B  = 3'b000;
    localparam logic [2:0] MEM_F3_H  = 3'b001;
    localparam logic [2:0] MEM_F3_W  = 3'b010;
    localparam logic [2:0] MEM_F3_BU = 3'b100;
    localparam logic [2:0] MEM_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_BUS  = 2'd1,
        MAU_RESP = 2'd2
    } mau_state_t;

    // A request faults on an unsupported width for its direction or when the
    // address is not naturally aligned for that width.
    function automatic logic access_fault(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic legal;
        logic misaligned;
        legal      = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            MEM_F3_B:  legal = 1'b1;
            MEM_F3_H:  begin legal = 1'b1;   misaligned = addr_lo[0];     end
            MEM_F3_W:  begin legal = 1'b1;   misaligned = |addr_lo;       end
            MEM_F3_BU: legal = !write;
            MEM_F3_HU: begin legal = !write; misaligned = addr_lo[0];     end
            default:   legal = 1'b0;
        endcase
        return !legal || misaligned;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes/replication toward the bus and
// load lane extraction with sign or zero extension back to the datapath.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  store_strb,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    logic [31:0] lane;

    // Narrow stores are replicated across every lane so the strobes alone
    // select which byte(s) the memory actually updates.
    always_comb begin
        store_strb  = 4'h0;
        store_lanes = store_data;
        case (funct3)
            MEM_F3_B: begin
                store_strb  = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
            end
            MEM_F3_H: begin
                store_strb  = 4'b0011 << {addr_lo[1], 1'b0};
                store_lanes = {2{store_data[15:0]}};
            end
            MEM_F3_W: store_strb = 4'hF;
            default:  store_strb = 4'h0;
        endcase
    end

    always_comb begin
        lane      = load_raw >> {addr_lo, 3'b000};
        load_data = lane;
        case (funct3)
            MEM_F3_B:  load_data = {{24{lane[7]}}, lane[7:0]};
            MEM_F3_H:  load_data = {{16{lane[15]}}, lane[15:0]};
            MEM_F3_BU: load_data = {24'h0, lane[7:0]};
            MEM_F3_HU: load_data = {16'h0, lane[15:0]};
            default:   load_data = lane;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle load/store engine: accepts one request, runs a valid/ready bus
// transaction with arbitrary wait states and returns extended load data.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata
);

    mau_state_t        state;
    mau_state_t        state_next;

    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [31:0]       wdata_q;
    logic              fault_q;
    logic [31:0]       rdata_q;

    logic              accept;
    logic [3:0]        store_strb;
    logic [31:0]       store_lanes;
    logic [31:0]       load_data;

    assign accept = (state == MAU_IDLE) && req_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MAU_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request fields are frozen at accept so every bus output stays stable
    // for the whole transaction regardless of what control drives meanwhile.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q  <= 1'b0;
            addr_q   <= '0;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
            fault_q  <= 1'b0;
        end else if (accept) begin
            write_q  <= req_write;
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            fault_q  <= access_fault(req_write, req_funct3, req_addr[1:0]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'h0;
        end else if ((state == MAU_BUS) && bus_ready && !write_q) begin
            rdata_q <= load_data;
        end
    end

    mem_lane_align u_align (
        .funct3      (funct3_q),
        .addr_lo     (addr_q[1:0]),
        .store_data  (wdata_q),
        .load_raw    (bus_rdata),
        .store_strb  (store_strb),
        .store_lanes (store_lanes),
        .load_data   (load_data)
    );

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        bus_valid  = 1'b0;
        bus_we     = 1'b0;
        bus_wstrb  = 4'h0;
        rsp_valid  = 1'b0;
        rsp_fault  = 1'b0;
        case (state)
            MAU_IDLE: begin
                req_ready = !reset;
                if (req_valid) begin
                    state_next = access_fault(req_write, req_funct3, req_addr[1:0])
                                 ? MAU_RESP : MAU_BUS;
                end
            end
            MAU_BUS: begin
                bus_valid = 1'b1;
                bus_we    = write_q;
                bus_wstrb = write_q ? store_strb : 4'h0;
                if (bus_ready) begin
                    state_next = MAU_RESP;
                end
            end
            MAU_RESP: begin
                rsp_valid  = 1'b1;
                rsp_fault  = fault_q;
                state_next = MAU_IDLE;
            end
            default: state_next = MAU_IDLE;
        endcase
    end

    assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus_wdata = store_lanes;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// transactions compared against a behavioural load/store model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_rdata = 32'h0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_fault(input logic wr, input logic [2:0] f3, input logic [1:0] lo);
        int width;
        width = 0;
        if (f3 == 3'd0 || f3 == 3'd4) width = 1;
        if (f3 == 3'd1 || f3 == 3'd5) width = 2;
        if (f3 == 3'd2) width = 4;
        if (wr && f3 > 3'd2) width = 0;
        if (width == 0) return 1'b1;
        return (lo % width) != 0;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] lo);
        if (f3 == 3'd0) return 4'(1 << lo);
        if (f3 == 3'd1) return (lo >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (f3 == 3'd1) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*lo +: 8];
        h = (lo >= 2) ? rd[31:16] : rd[15:0];
        case (f3)
            3'd0:    return 32'($signed(b));
            3'd1:    return 32'($signed(h));
            3'd4:    return {24'h0, b};
            3'd5:    return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    // Issues one request at a negedge in IDLE and walks it to completion.
    task automatic apply_stimulus(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rd, input int waits);
        logic flt;
        flt = model_fault(wr, f3, addr[1:0]);
        check("req_ready_idle", {31'h0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        if (flt) begin
            check("fault_rsp_valid", {31'h0, rsp_valid}, 32'd1);
            check("fault_rsp_fault", {31'h0, rsp_fault}, 32'd1);
            check("fault_bus_valid", {31'h0, bus_valid}, 32'd0);
            check("fault_rdata_kept", rsp_rdata, model_rdata);
            @(negedge clk);
        end else begin
            for (int i = 0; i <= waits; i++) begin
                check("bus_valid", {31'h0, bus_valid}, 32'd1);
                check("bus_rsp_valid", {31'h0, rsp_valid}, 32'd0);
                check("bus_req_ready", {31'h0, req_ready}, 32'd0);
                check("bus_we", {31'h0, bus_we}, {31'h0, wr});
                check("bus_addr", bus_addr, {addr[31:2], 2'b00});
                check("bus_wstrb", {28'h0, bus_wstrb}, wr ? {28'h0, model_strb(f3, addr[1:0])} : 32'h0);
                if (wr) check("bus_wdata", bus_wdata, model_wdata(f3, wd));
                bus_ready = (i == waits);
                bus_rdata = (i == waits) ? rd : $urandom;
                @(negedge clk);
            end
            bus_ready = 1'b0;
            bus_rdata = $urandom;
            if (!wr) model_rdata = model_load(f3, addr[1:0], rd);
            check("rsp_valid", {31'h0, rsp_valid}, 32'd1);
            check("rsp_fault", {31'h0, rsp_fault}, 32'd0);
            check("rsp_bus_valid", {31'h0, bus_valid}, 32'd0);
            check("rsp_rdata", rsp_rdata, model_rdata);
            @(negedge clk);
        end
        check_output();
    endtask

    task automatic check_output();
        check("idle_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("idle_bus_valid", {31'h0, bus_valid}, 32'd0);
        check("idle_rdata", rsp_rdata, model_rdata);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_funct3 = 3'd0;
        req_wdata  = 32'h0;
        bus_ready  = 1'b0;
        bus_rdata  = 32'h0;
        $display("[TB] starting");

        @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'd0);
        check("rst_bus_valid", {31'h0, bus_valid}, 32'd0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("rst_bus_wstrb", {28'h0, bus_wstrb}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        apply_stimulus(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        apply_stimulus(1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0);
        apply_stimulus(1'b0, 3'd0, 32'h103, 32'h0, 32'hA5000000, 0);
        check("lb_const", rsp_rdata, 32'hFFFFFFA5);
        apply_stimulus(1'b0, 3'd4, 32'h103, 32'h0, 32'hA5000000, 1);
        check("lbu_const", rsp_rdata, 32'h000000A5);
        apply_stimulus(1'b0, 3'd1, 32'h102, 32'h0, 32'h80010000, 3);
        check("lh_const", rsp_rdata, 32'hFFFF8001);
        bus_ready = 1'b1;
        apply_stimulus(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0);
        bus_ready = 1'b0;
        check("lw_fault_rdata_const", rsp_rdata, 32'hFFFF8001);
        apply_stimulus(1'b1, 3'd3, 32'h200, 32'h12345678, 32'h0, 0);

        // Reset while the bus is waiting must drop bus_valid immediately.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'd1;
        req_addr   = 32'h102;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_bus_valid", {31'h0, bus_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_bus_valid", {31'h0, bus_valid}, 32'd0);
        check("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("mid_rst_req_ready", {31'h0, req_ready}, 32'd0);
        check("mid_rst_rdata", rsp_rdata, 32'h0);
        model_rdata = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        apply_stimulus(1'b0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 2);

        // Continuous req_valid with a zero-wait bus: one accept every 3 cycles.
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h400;
        req_wdata  = 32'h11223344;
        bus_ready  = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check("stream_req_ready", {31'h0, req_ready}, (k % 3 == 0) ? 32'd1 : 32'd0);
            check("stream_bus_valid", {31'h0, bus_valid}, (k % 3 == 1) ? 32'd1 : 32'd0);
            check("stream_rsp_valid", {31'h0, rsp_valid}, (k % 3 == 2) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        bus_ready = 1'b0;
        check_output();

        for (int n = 0; n < 60; n++) begin
            apply_stimulus(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom,
                           $urandom, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
